// File: rtl/sr_ff_driver.sv
// Request driver for an SR flip-flop: one S or R pulse per accepted target bit, then Q is watched for up to TIMEOUT cycles.
// Done is 1 cycle after accept on a no-op and 3 cycles after accept on a drive; req_ready is low from accept until back in IDLE.
module sr_ff_driver #(
    parameter int TIMEOUT = 4,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_data,
    input  logic             Q_fb,
    output logic             S,
    output logic             R,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int WCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_WAIT,
        ST_DONE,
        ST_ERR
    } state_t;

    state_t            r_state;
    logic              r_tgt;
    logic [WCNT_W-1:0] r_wcnt;

    assign req_ready = (r_state == ST_IDLE);
    assign busy      = ~req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_tgt   <= 1'b0;
            r_wcnt  <= '0;
            S       <= 1'b0;
            R       <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            err_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_tgt <= req_data;
                        // Cell already holds the target: skip the pulse entirely.
                        if (Q_fb == req_data) begin
                            r_state <= ST_DONE;
                            done    <= 1'b1;
                        end else begin
                            r_state <= ST_DRIVE;
                            S       <= req_data;
                            R       <= ~req_data;
                        end
                    end
                end
                ST_DRIVE: begin
                    S       <= 1'b0;
                    R       <= 1'b0;
                    r_wcnt  <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (Q_fb == r_tgt) begin
                        r_state <= ST_DONE;
                        done    <= 1'b1;
                    end else if (r_wcnt == WCNT_LAST) begin
                        r_state <= ST_ERR;
                        err     <= 1'b1;
                        if (err_cnt != {CNT_W{1'b1}}) begin
                            err_cnt <= err_cnt + CNT_W'(1);
                        end
                    end else begin
                        r_wcnt <= r_wcnt + WCNT_W'(1);
                    end
                end
                ST_DONE: begin
                    done    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                ST_ERR: begin
                    err     <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    S       <= 1'b0;
                    R       <= 1'b0;
                    done    <= 1'b0;
                    err     <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sr_ff_driver.sv
// Directed bench for sr_ff_driver with a behavioural SR flip-flop on Q_fb.
module tb_sr_ff_driver;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic       req_data;
    logic       Q_fb;
    logic       S;
    logic       R;
    logic       busy;
    logic       done;
    logic       err;
    logic [1:0] err_cnt;

    logic q_model   = 1'b0;
    logic q_load    = 1'b0;
    logic q_load_val = 1'b0;
    logic force0    = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sr_ff_driver #(.TIMEOUT(4), .CNT_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .Q_fb      (Q_fb),
        .S         (S),
        .R         (R),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_cnt   (err_cnt)
    );

    always @(posedge clk) begin
        if (q_load)   q_model <= q_load_val;
        else if (S)   q_model <= 1'b1;
        else if (R)   q_model <= 1'b0;
    end

    assign Q_fb = force0 ? 1'b0 : q_model;

    always @(negedge clk) begin
        checks++;
        assert (!(S && R)) else begin
            errors++;
            $error("FAIL s_and_r observed=%0b%0b expected=not both 1", S, R);
        end
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chkc(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_idle_outs(input string tag);
        chk1({tag, "_S"}, S, 1'b0);
        chk1({tag, "_R"}, R, 1'b0);
        chk1({tag, "_done"}, done, 1'b0);
        chk1({tag, "_err"}, err, 1'b0);
        chk1({tag, "_ready"}, req_ready, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_data  = 1'b0;
        @(negedge clk);
        cyc();
        chk_idle_outs("reset");
        chkc("reset_errcnt", err_cnt, 2'd0);
        chk1("reset_busy", busy, 1'b0);
        rst_n = 1'b1;

        q_load = 1'b1; q_load_val = 1'b0;
        cyc();
        q_load = 1'b0;
        chk1("preload_q0", Q_fb, 1'b0);

        // Set: Q=0, target 1
        req_valid = 1'b1; req_data = 1'b1;
        cyc();
        req_valid = 1'b0;
        chk1("set_e0_S", S, 1'b1);
        chk1("set_e0_R", R, 1'b0);
        chk1("set_e0_ready", req_ready, 1'b0);
        chk1("set_e0_busy", busy, 1'b1);
        chk1("set_e0_done", done, 1'b0);
        cyc();
        chk1("set_e1_S", S, 1'b0);
        chk1("set_e1_q", Q_fb, 1'b1);
        chk1("set_e1_done", done, 1'b0);
        cyc();
        chk1("set_e2_done", done, 1'b1);
        chk1("set_e2_ready", req_ready, 1'b0);
        cyc();
        chk1("set_e3_done", done, 1'b0);
        chk1("set_e3_ready", req_ready, 1'b1);
        chkc("set_errcnt", err_cnt, 2'd0);

        // Clear: Q=1, target 0
        req_valid = 1'b1; req_data = 1'b0;
        cyc();
        req_valid = 1'b0;
        chk1("clr_e0_R", R, 1'b1);
        chk1("clr_e0_S", S, 1'b0);
        cyc();
        chk1("clr_e1_R", R, 1'b0);
        chk1("clr_e1_q", Q_fb, 1'b0);
        cyc();
        chk1("clr_e2_done", done, 1'b1);
        cyc();
        chk1("clr_e3_done", done, 1'b0);
        chk1("clr_e3_ready", req_ready, 1'b1);

        // No-op: Q=1, target 1
        q_load = 1'b1; q_load_val = 1'b1;
        cyc();
        q_load = 1'b0;
        req_valid = 1'b1; req_data = 1'b1;
        cyc();
        req_valid = 1'b0;
        chk1("noop_e0_done", done, 1'b1);
        chk1("noop_e0_S", S, 1'b0);
        chk1("noop_e0_R", R, 1'b0);
        chk1("noop_e0_ready", req_ready, 1'b0);
        cyc();
        chk1("noop_e1_done", done, 1'b0);
        chk1("noop_e1_ready", req_ready, 1'b1);

        // Timeout: Q held at 0, target 1
        force0 = 1'b1;
        req_valid = 1'b1; req_data = 1'b1;
        cyc();
        req_valid = 1'b0;
        chk1("to_e0_S", S, 1'b1);
        cyc();
        chk1("to_e1_S", S, 1'b0);
        for (int k = 2; k <= 4; k++) begin
            cyc();
            chk1("to_wait_err", err, 1'b0);
            chk1("to_wait_done", done, 1'b0);
            chk1("to_wait_busy", busy, 1'b1);
        end
        cyc();
        chk1("to_e5_err", err, 1'b1);
        chk1("to_e5_done", done, 1'b0);
        chkc("to_e5_errcnt", err_cnt, 2'd1);
        cyc();
        chk1("to_e6_err", err, 1'b0);
        chk1("to_e6_ready", req_ready, 1'b1);

        // Four more back-to-back timeouts: counter saturates at 3
        req_valid = 1'b1; req_data = 1'b1;
        for (int i = 0; i < 4; i++) begin
            repeat (5) cyc();
            chk1("sat_e4_err", err, 1'b0);
            cyc();
            chk1("sat_e5_err", err, 1'b1);
            chkc("sat_errcnt", err_cnt, (i == 0) ? 2'd2 : 2'd3);
            cyc();
            chk1("sat_e6_err", err, 1'b0);
            chk1("sat_e6_ready", req_ready, 1'b1);
        end
        req_valid = 1'b0;
        cyc();
        chkc("sat_hold", err_cnt, 2'd3);

        // Reset during WAIT
        req_valid = 1'b1; req_data = 1'b1;
        cyc();
        req_valid = 1'b0;
        cyc();
        cyc();
        chk1("mid_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_idle_outs("midrst");
        chkc("midrst_errcnt", err_cnt, 2'd0);
        cyc();
        cyc();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cyc();
            chk1("post_done", done, 1'b0);
            chk1("post_err", err, 1'b0);
        end
        chk1("post_ready", req_ready, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
